// File: rtl/timer_counter_if.sv
// Bridge-side bus for one timer slot: word address, write strobe/data, read data and IRQ.
// Purely wiring; no storage, no backpressure (writes always accepted in one cycle).
interface timer_counter_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or periodic IRQ.
// Writes land on the next edge, reads are combinational; never stalls the bridge.
module timer_counter (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic [1:0]  w_sel;
  logic        w_en;
  logic [1:0]  w_mode;
  logic        w_im;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic [31:0] w_dout;
  logic        w_unused_addr;

  assign w_sel         = bus.Addr[1:0];
  assign w_unused_addr = &{1'b0, bus.Addr[29:2]};
  assign w_en          = r_ctrl[0];
  assign w_mode        = r_ctrl[2:1];
  assign w_im          = r_ctrl[3];
  assign w_wr_ctrl     = bus.WE && (w_sel == 2'b00);
  assign w_wr_pre      = bus.WE && (w_sel == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= bus.Din[3:0];
      if (w_wr_pre)  r_preset <= bus.Din;
      if (w_wr_ctrl || w_wr_pre) r_irq_flag <= 1'b0;

      // Later assignments below win: a terminal count sets the flag over a same-edge clear.
      case (r_state)
        IDLE: if (w_en) r_state <= LOAD;
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!w_en) begin
            r_state <= IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count    <= 32'd0;
            r_irq_flag <= 1'b1;
            r_state    <= INT;
          end
        end
        INT: begin
          r_state <= IDLE;
          if (w_mode == 2'b01) begin
            r_irq_flag <= 1'b0;
          end else if (!w_wr_ctrl) begin
            // A CTRL write on this same edge keeps the value software asked for.
            r_ctrl[0] <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_dout = 32'd0;
    case (w_sel)
      2'b00:   w_dout = {28'd0, r_ctrl};
      2'b01:   w_dout = r_preset;
      2'b10:   w_dout = r_count;
      default: w_dout = 32'd0;
    endcase
  end

  assign bus.Dout = w_dout;
  assign bus.IRQ  = w_im & r_irq_flag;

endmodule
